// File: rtl/pcpi_issue_ctrl.sv
// pcpi_issue_ctrl
//   Issues one core instruction at a time to the PCPI coprocessor bus and
//   returns the result. If no coprocessor answers in time, it returns an
//   "illegal instruction" response.
//
//   Parameter
//     TIMEOUT_CYCLES : consecutive BUSY cycles with neither wait nor ready
//                      before the instruction counts as illegal (2..255)
//
//   Ports
//     clk, resetn          : clock; synchronous active-low reset
//     cmd_valid/cmd_ready  : command handshake from the core
//     cmd_insn/rs1/rs2     : instruction word and operands
//     pcpi_valid           : request strobe to the coprocessors
//     pcpi_insn/rs1/rs2    : latched copy of the accepted command
//     pcpi_wr/rd/wait/ready: coprocessor response
//     rsp_valid/rsp_ready  : result handshake to the core
//     rsp_wr/rd/illegal    : captured write-enable, result and timeout flag
module pcpi_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_illegal
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic [31:0] r_insn;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic        r_rsp_wr;
  logic [31:0] r_rsp_rd;
  logic        r_rsp_illegal;
  logic        w_accept;
  logic        w_done;
  logic        w_timeout;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = BUSY;
        end
      end
      BUSY: begin
        // ready wins over both wait and a coinciding timeout
        if (pcpi_ready) begin
          w_done = 1'b1;
          w_next = RESP;
        end else if (!pcpi_wait && (r_cnt == LP_LAST)) begin
          w_timeout = 1'b1;
          w_next    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_insn        <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rsp_wr      <= 1'b0;
      r_rsp_rd      <= '0;
      r_rsp_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_insn <= cmd_insn;
        r_rs1  <= cmd_rs1;
        r_rs2  <= cmd_rs2;
        r_cnt  <= '0;
      end
      if (r_state == BUSY) begin
        if (w_done) begin
          r_rsp_wr      <= pcpi_wr;
          r_rsp_rd      <= pcpi_rd;
          r_rsp_illegal <= 1'b0;
        end else if (pcpi_wait) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) begin
            r_rsp_wr      <= 1'b0;
            r_rsp_rd      <= '0;
            r_rsp_illegal <= 1'b1;
          end
        end
      end
    end
  end

  assign cmd_ready   = (r_state == IDLE);
  assign pcpi_valid  = (r_state == BUSY);
  assign rsp_valid   = (r_state == RESP);
  assign pcpi_insn   = r_insn;
  assign pcpi_rs1    = r_rs1;
  assign pcpi_rs2    = r_rs2;
  assign rsp_wr      = r_rsp_wr;
  assign rsp_rd      = r_rsp_rd;
  assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Testbench for pcpi_issue_ctrl: a cycle-driven coprocessor responder plus a
// scoreboard of expected responses.
module tb_pcpi_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn, cmd_rs1, cmd_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait, pcpi_ready;
  logic        rsp_valid, rsp_ready;
  logic        rsp_wr;
  logic [31:0] rsp_rd;
  logic        rsp_illegal;

  localparam logic [31:0] INSN_MUL   = 32'h02B50533;
  localparam logic [31:0] INSN_MULHU = 32'h02B53533;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
    logic        ill;
  } rsp_t;

  rsp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] cur_insn, cur_rs1, cur_rs2;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Coprocessor behaviour: MUL low word or MULHU high word.
  function automatic logic [31:0] mul_model(input logic [31:0] insn,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return (insn[14:12] == 3'b011) ? p[63:32] : p[31:0];
  endfunction

  // Called at a negedge: offers a command that must be accepted at the next edge.
  task automatic issue_cmd(input logic [31:0] insn, input logic [31:0] a,
                           input logic [31:0] b, input bit push,
                           input logic e_wr, input logic [31:0] e_rd,
                           input logic e_ill);
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_insn  = insn;
    cmd_rs1   = a;
    cmd_rs2   = b;
    cur_insn  = insn;
    cur_rs1   = a;
    cur_rs2   = b;
    chk("cmd_ready_idle", cmd_ready, 1);
    if (push) begin
      e.wr  = e_wr;
      e.rd  = e_rd;
      e.ill = e_ill;
      sb.push_back(e);
    end
  endtask

  // Plays the coprocessor until rsp_valid appears; returns at that negedge.
  task automatic serve(input bit use_mul, input int ready_at, input int wait_n,
                       input logic [31:0] rd_val, input logic wr_val,
                       input int exp_busy);
    int   busy;
    bit   got;
    rsp_t e;
    busy = 0;
    got  = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      cmd_valid  = 1'b0;
      pcpi_ready = 1'b0;
      pcpi_wait  = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = '0;
      if (rsp_valid) begin
        got = 1;
      end else if (pcpi_valid) begin
        busy++;
        chk("insn_hold", pcpi_insn, cur_insn);
        chk("rs1_hold", pcpi_rs1, cur_rs1);
        chk("rs2_hold", pcpi_rs2, cur_rs2);
        if (busy <= wait_n) pcpi_wait = 1'b1;
        if (ready_at != 0 && busy == ready_at) begin
          pcpi_ready = 1'b1;
          pcpi_wr    = wr_val;
          pcpi_rd    = use_mul ? mul_model(pcpi_insn, pcpi_rs1, pcpi_rs2) : rd_val;
        end
      end
    end
    chk("rsp_seen", 32'(got), 1);
    chk("busy_cycles", busy, exp_busy);
    if (got) begin
      chk("pcpi_valid_in_resp", pcpi_valid, 0);
      chk("insn_hold_resp", pcpi_insn, cur_insn);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("rsp_wr", rsp_wr, e.wr);
        chk("rsp_rd", rsp_rd, e.rd);
        chk("rsp_illegal", rsp_illegal, e.ill);
      end
    end
  endtask

  task automatic back_to_idle();
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    cmd_valid  = 1'b0;
    cmd_insn   = '0;
    cmd_rs1    = '0;
    cmd_rs2    = '0;
    pcpi_wr    = 1'b0;
    pcpi_rd    = '0;
    pcpi_wait  = 1'b0;
    pcpi_ready = 1'b0;
    rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_pcpi_valid", pcpi_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_pcpi_insn", pcpi_insn, 0);
    chk("rst_rsp_rd", rsp_rd, 0);
    chk("rst_rsp_illegal", rsp_illegal, 0);

    // First cycle after reset release accepts a command.
    resetn = 1'b1;
    issue_cmd(INSN_MUL, 32'd7, 32'd6, 1, 1'b1, 32'h0000002A, 1'b0);
    serve(1, 3, 0, '0, 1'b1, 3);
    back_to_idle();

    issue_cmd(INSN_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1'b1, 32'hFFFFFFFE, 1'b0);
    serve(1, 3, 0, '0, 1'b1, 3);
    back_to_idle();

    // No responder: timeout after exactly 16 BUSY cycles.
    issue_cmd(32'h0000000B, 32'h11, 32'h22, 1, 1'b0, 32'h0, 1'b1);
    serve(0, 0, 0, '0, 1'b0, 16);
    back_to_idle();

    // Long wait holds off the timeout.
    issue_cmd(32'h0200000B, 32'h33, 32'h44, 1, 1'b1, 32'h12345678, 1'b0);
    serve(0, 41, 40, 32'h12345678, 1'b1, 41);
    back_to_idle();

    // Ready and wait in the same cycle: ready wins.
    issue_cmd(32'h0400000B, 32'h55, 32'h66, 1, 1'b0, 32'hCAFEF00D, 1'b0);
    serve(0, 2, 2, 32'hCAFEF00D, 1'b0, 2);
    back_to_idle();

    // Ready in the last cycle before timeout: ready wins.
    issue_cmd(32'h0600000B, 32'h77, 32'h88, 1, 1'b1, 32'h0BADBEEF, 1'b0);
    serve(0, 16, 0, 32'h0BADBEEF, 1'b1, 16);
    back_to_idle();

    // Wait clears the counter, then silence: 3 + 16 BUSY cycles.
    issue_cmd(32'h0800000B, 32'h99, 32'hAA, 1, 1'b0, 32'h0, 1'b1);
    serve(0, 0, 3, '0, 1'b0, 19);
    back_to_idle();

    // Result held while the core stalls; no second issue meanwhile.
    rsp_ready = 1'b0;
    issue_cmd(INSN_MUL, 32'd9, 32'd5, 1, 1'b1, 32'd45, 1'b0);
    serve(1, 3, 0, '0, 1'b1, 3);
    cmd_valid = 1'b1;
    cmd_insn  = INSN_MULHU;
    cmd_rs1   = 32'h80000000;
    cmd_rs2   = 32'd4;
    for (int i = 0; i < 4; i++) begin
      pcpi_ready = 1'b1;
      pcpi_wr    = 1'b0;
      pcpi_rd    = 32'hDEADDEAD;
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rd", rsp_rd, 32'd45);
      chk("hold_rsp_wr", rsp_wr, 1);
      chk("hold_rsp_ill", rsp_illegal, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_no_issue", pcpi_valid, 0);
    end
    pcpi_ready = 1'b0;
    pcpi_rd    = '0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    chk("gap_rsp_valid", rsp_valid, 0);
    chk("gap_pcpi_valid", pcpi_valid, 0);
    issue_cmd(INSN_MULHU, 32'h80000000, 32'd4, 1, 1'b1, 32'd2, 1'b0);
    serve(1, 3, 0, '0, 1'b1, 3);
    back_to_idle();

    // Reset mid-BUSY with counter at 5: transaction discarded.
    issue_cmd(32'h0A00000B, 32'h1, 32'h2, 0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("pre_rst_busy", pcpi_valid, 1);
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_pcpi_valid", pcpi_valid, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_pcpi_insn", pcpi_insn, 0);
    chk("midrst_pcpi_rs1", pcpi_rs1, 0);
    chk("midrst_rsp_ill", rsp_illegal, 0);
    resetn = 1'b1;
    issue_cmd(INSN_MUL, 32'd12, 32'd12, 1, 1'b1, 32'd144, 1'b0);
    serve(1, 3, 0, '0, 1'b1, 3);
    back_to_idle();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcpi_issue_ctrl.md
PCPI_ISSUE_CTRL -- requirements
Module: pcpi_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: consecutive no-wait, no-ready cycles before an instruction is declared illegal; legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid, input, 1 bit: core offers an instruction for coprocessor dispatch.
REQ-005 SHALL have port cmd_ready, output, 1 bit: block accepts a command this cycle.
REQ-006 SHALL have ports cmd_insn, cmd_rs1 and cmd_rs2, each input, 32 bits: instruction word and operands.
REQ-007 SHALL have port pcpi_valid, output, 1 bit: request strobe to coprocessors.
REQ-008 SHALL have ports pcpi_insn, pcpi_rs1 and pcpi_rs2, each output, 32 bits: registered copies of the latched command.
REQ-009 SHALL have inputs pcpi_wr (1 bit), pcpi_rd (32 bits), pcpi_wait (1 bit) and pcpi_ready (1 bit): coprocessor response.
REQ-010 SHALL have port rsp_valid, output, 1 bit: result available to the core.
REQ-011 SHALL have port rsp_ready, input, 1 bit: core consumes the result.
REQ-012 SHALL have outputs rsp_wr (1 bit), rsp_rd (32 bits) and rsp_illegal (1 bit): captured write-enable, result, and timeout flag.

Function
REQ-013 SHALL implement the states IDLE, BUSY and RESP; cmd_ready = (state==IDLE), pcpi_valid = (state==BUSY), rsp_valid = (state==RESP), each decoded from state only.
REQ-014 SHALL, in IDLE with cmd_valid=1, latch cmd_insn/rs1/rs2 into pcpi_insn/rs1/rs2, clear the timeout counter and enter BUSY at the next edge; pcpi_valid therefore rises 1 cycle after acceptance.
REQ-015 SHALL hold pcpi_insn/rs1/rs2 stable for the whole of BUSY and RESP; they change only on acceptance.
REQ-016 SHALL, in BUSY with pcpi_ready=1, capture pcpi_wr into rsp_wr and pcpi_rd into rsp_rd, clear rsp_illegal and enter RESP; pcpi_valid is low from the next cycle.
REQ-017 SHALL, in BUSY with pcpi_ready=0 and pcpi_wait=1, clear the counter to 0 and remain in BUSY; pcpi_wait holds off the timeout indefinitely.
REQ-018 SHALL, in BUSY with pcpi_ready=0 and pcpi_wait=0, increment the counter; when the counter equals TIMEOUT_CYCLES-1 in such a cycle, set rsp_illegal=1, rsp_wr=0, rsp_rd=0 and enter RESP.
REQ-019 SHALL give pcpi_ready priority over timeout and over pcpi_wait when they coincide in the same cycle.
REQ-020 SHALL ignore pcpi_ready, pcpi_wait, pcpi_wr and pcpi_rd outside BUSY.
REQ-021 SHALL, in RESP, hold rsp_wr/rsp_rd/rsp_illegal stable until rsp_ready=1, then enter IDLE; at least one IDLE cycle separates transactions.
REQ-022 SHALL size the counter at 8 bits; it never wraps because the timeout fires at TIMEOUT_CYCLES-1.
REQ-023 SHALL ignore cmd_valid in BUSY and RESP (no queuing).

Reset
REQ-024 SHALL, on a clock edge with resetn=0, force IDLE, counter=0, all pcpi_* outputs=0 and all rsp_* outputs=0, regardless of state.
REQ-025 SHALL, on reset in BUSY, drop pcpi_valid at that edge and discard the transaction with no rsp_valid; on reset in RESP, discard the pending result.
REQ-026 SHALL accept a new command in the first cycle after resetn returns high.

Verification
REQ-027 Responder is the fast 2-cycle multiplier; MUL (funct7=0000001, funct3=000, opcode=0110011), rs1=7, rs2=6, rsp_ready held 1 -> pcpi_valid high 3 cycles, rsp_valid 1 cycle later with rsp_rd=0x0000002A, rsp_wr=1, rsp_illegal=0.
REQ-028 MULHU, rs1=rs2=0xFFFFFFFF -> rsp_rd=0xFFFFFFFE, rsp_wr=1; pcpi_valid is low in the cycle after pcpi_ready, so the multiplier is not re-triggered.
REQ-029 No responder (ready=wait=0), TIMEOUT_CYCLES=16 -> pcpi_valid high exactly 16 cycles, then rsp_valid=1, rsp_illegal=1, rsp_rd=0, rsp_wr=0.
REQ-030 pcpi_wait=1 for 40 cycles, then wait=0 and ready=1 with rd=0x12345678, wr=1 -> no timeout, rsp_rd=0x12345678; ready and wait both 1 in one cycle -> ready wins.
REQ-031 rsp_ready=0 for 5 cycles in RESP with cmd_valid=1 -> rsp_* stable, cmd_ready=0, no second issue; after rsp_ready=1 -> one IDLE cycle, then the new command is accepted.
REQ-032 resetn=0 for one edge mid-BUSY (counter=5) -> pcpi_valid=0 and all outputs 0 after that edge, no rsp_valid; a command offered the following cycle completes normally.
